// File: rtl/score_display_driver.sv
// Three-digit multiplexed 7-segment score driver with game-over blinking.
// Define SCORE_DISP_LZB_EN to compile in leading-zero blanking.
module score_display_driver #(
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 250
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic [3:0] bcd_ones_i,
  input  logic [3:0] bcd_tens_i,
  input  logic [3:0] bcd_hundreds_i,
  input  logic       load_i,
  input  logic       game_over_i,
  output logic [6:0] seg_o,
  output logic [2:0] an_o,
  output logic       bcd_err_o
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [3:0]    ones_q, tens_q, hund_q;
  logic [PW-1:0] presc_q;
  logic [1:0]    idx_q;
  logic [BW-1:0] blink_q;
  logic          phase_q;
  logic [6:0]    seg_q, seg_d;
  logic [2:0]    an_q, an_d;
  logic          err_q;

  logic          tick, blink_wrap, lzb_blank, show;
  logic [3:0]    digit;
  logic [2:0]    an_sel;

  assign tick       = (presc_q == PW'(SCAN_DIV - 1));
  assign blink_wrap = (blink_q == BW'(BLINK_DIV - 1));

  function automatic logic [6:0] dec7(input logic [3:0] v);
    case (v)
      4'd0:    dec7 = 7'h3F;
      4'd1:    dec7 = 7'h06;
      4'd2:    dec7 = 7'h5B;
      4'd3:    dec7 = 7'h4F;
      4'd4:    dec7 = 7'h66;
      4'd5:    dec7 = 7'h6D;
      4'd6:    dec7 = 7'h7D;
      4'd7:    dec7 = 7'h07;
      4'd8:    dec7 = 7'h7F;
      4'd9:    dec7 = 7'h6F;
      default: dec7 = 7'h40;
    endcase
  endfunction

  always_comb begin
    digit     = ones_q;
    an_sel    = 3'b001;
    lzb_blank = 1'b0;
    case (idx_q)
      2'd1:    begin digit = tens_q; an_sel = 3'b010; end
      2'd2:    begin digit = hund_q; an_sel = 3'b100; end
      default: begin digit = ones_q; an_sel = 3'b001; end
    endcase
`ifdef SCORE_DISP_LZB_EN
    // A zero is never a dash, so testing for zero keeps dash digits visible.
    if (idx_q == 2'd2 && hund_q == 4'd0)                    lzb_blank = 1'b1;
    if (idx_q == 2'd1 && hund_q == 4'd0 && tens_q == 4'd0) lzb_blank = 1'b1;
`endif
    // Dropping game_over lights the display on the very next edge.
    show  = (phase_q | ~game_over_i) & ~lzb_blank;
    seg_d = show ? dec7(digit) : 7'h00;
    an_d  = show ? an_sel : 3'b000;
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      ones_q  <= '0;
      tens_q  <= '0;
      hund_q  <= '0;
      presc_q <= '0;
      idx_q   <= '0;
      blink_q <= '0;
      phase_q <= 1'b1;
      seg_q   <= '0;
      an_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      if (load_i) begin
        ones_q <= bcd_ones_i;
        tens_q <= bcd_tens_i;
        hund_q <= bcd_hundreds_i;
        if (bcd_ones_i > 4'd9 || bcd_tens_i > 4'd9 || bcd_hundreds_i > 4'd9)
          err_q <= 1'b1;
      end
      presc_q <= tick ? '0 : presc_q + PW'(1);
      if (tick) idx_q <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
      if (!game_over_i) begin
        blink_q <= '0;
        phase_q <= 1'b1;
      end else if (tick) begin
        if (blink_wrap) begin
          blink_q <= '0;
          phase_q <= ~phase_q;
        end else begin
          blink_q <= blink_q + BW'(1);
        end
      end
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg_o     = seg_q;
  assign an_o      = an_q;
  assign bcd_err_o = err_q;

endmodule

// File: doc/score_display_driver.md
SCORE_DISPLAY_DRIVER -- requirements
Module: score_display_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, meaning clk cycles per digit slot (min 2).
REQ-002 SHALL have parameter BLINK_DIV, default 250, meaning scan ticks per blink half-period (min 1).
REQ-003 clk  input  1  clock, all state on rising edge.
REQ-004 nRst  input  1  reset, asynchronous, active-low.
REQ-005 bcd_ones, bcd_tens, bcd_hundreds  input  4 each  score digits from score tracker.
REQ-006 load  input  1  single-cycle strobe; capture the three digits.
REQ-007 game_over  input  1  level; display blinks while high.
REQ-008 seg  output  7  segment drive {g,f,e,d,c,b,a}, active-high, registered.
REQ-009 an  output  3  digit enable, one-hot or zero; bit0 ones, bit1 tens, bit2 hundreds; registered.
REQ-010 bcd_err  output  1  sticky flag: an illegal digit (>9) was captured.

Function
REQ-011 Shadow registers SHALL capture all three digits on the edge where load=1; with load=0 they SHALL hold.
REQ-012 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; the wrap cycle is the scan tick.
REQ-013 Digit index SHALL advance 0->1->2->0 on each scan tick; no other transitions; no index 3.
REQ-014 seg/an SHALL be updated every edge from the index and shadow values present before that edge (1-cycle latency).
REQ-015 Decode: 0..9 standard patterns (0=7'h3F, 1=7'h06, 2=7'h5B, 3=7'h4F, 4=7'h66, 5=7'h6D, 6=7'h7D, 7=7'h07, 8=7'h7F, 9=7'h6F); values 10..15 SHALL show a dash (7'h40).
REQ-016 bcd_err SHALL set on any load edge capturing a digit >9 and clear only on reset.
REQ-017 A blanked digit SHALL drive an=000 and seg=7'h00 for its slot; the index still advances.
REQ-018 Blink: while game_over=1, a blink counter SHALL count scan ticks and toggle a phase bit every BLINK_DIV ticks; phase off forces an=000 and seg=7'h00.
REQ-019 While game_over=0, blink counter SHALL be held at 0 and phase forced on; a rising game_over SHALL start with phase on.
REQ-020 Simultaneous load and scan tick: both SHALL take effect on the same edge; next output uses new index and new data.
REQ-021 load during game_over SHALL capture normally; blink timing SHALL be unaffected.

Reset
REQ-022 While nRst=0: shadows=0, prescaler=0, index=0, blink counter=0, phase=on, seg=7'h00, an=000, bcd_err=0.
REQ-023 First edge after reset release SHALL drive an=001, seg=7'h3F.
REQ-024 Reset asserted mid-scan or mid-blink SHALL return every register to REQ-022 values immediately.

Configuration
REQ-025 Macro SCORE_DISP_LZB_EN SHALL compile in leading-zero blanking.
REQ-026 With SCORE_DISP_LZB_EN: hundreds blanked when its value is 0; tens blanked when hundreds and tens are both 0; ones never blanked; dash digits never blanked.
REQ-027 Without SCORE_DISP_LZB_EN: no digit is ever blanked by value; only blink (REQ-018) blanks.

Verification (SCAN_DIV=4, BLINK_DIV=2)
REQ-028 Reset release, no load -> an cycles 001,010,100 every 4 clocks; seg=7'h3F on ones slot; tens/hundreds slots an=000 with LZB_EN, seg=7'h3F without.
REQ-029 load with 1/2/3 (score 123) -> within 12 clocks observe an=001 seg=7'h4F, an=010 seg=7'h5B, an=100 seg=7'h06.
REQ-030 load 0/0/7, LZB_EN -> ones slot seg=7'h07, tens and hundreds slots an=000; without macro tens/hundreds seg=7'h3F.
REQ-031 load with tens=4'hC -> tens slot seg=7'h40, bcd_err=1 and stays 1 after a later legal load.
REQ-032 game_over=1 for 48 clocks -> an alternates 8 clocks active, 8 clocks 000; drop game_over -> active on next edge, counter cleared.
REQ-033 nRst pulsed low mid-blink off-phase -> an=000, seg=7'h00, bcd_err=0 during reset; an=001 seg=7'h3F on first edge after release.
